// File: rtl/dct_row_feeder.sv
// dct_row_feeder: ping-pong row buffer that streams each row to the DCT array
// as a butterfly-ordered even (sum) pass followed by an odd (difference) pass.
module dct_row_feeder #(
    parameter int DATA_WIDTH     = 8,
    parameter int N              = 8,
    parameter int ROWS_PER_BLOCK = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N*DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   x,
    output logic                    sumDiffSel,
    output logic                    load,
    output logic                    x_valid,
    output logic                    block_done
);
    localparam int IW = $clog2(N);
    localparam int RW = ROWS_PER_BLOCK > 1 ? $clog2(ROWS_PER_BLOCK) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

    state_t state, state_n;
    logic [IW-1:0] idx, idx_n, sel;
    logic [1:0][N-1:0][DATA_WIDTH-1:0] mem;
    logic [1:0] full;
    logic wr_slot, rd_slot;
    logic [RW-1:0] row_cnt;
    logic acc, last, row_end;
    logic [DATA_WIDTH-1:0] x_n;
    logic sd_n, load_n, xv_n, bd_n;

    assign s_ready = ~(full[0] & full[1]);
    assign acc     = s_valid & s_ready;
    assign last    = idx == LAST;
    assign row_end = state == ODD && last;
    // Butterfly pairing: even idx walks up from s0, odd idx walks down from s[N-1].
    assign sel     = idx[0] ? LAST - (idx >> 1) : idx >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: if (|full) begin
                state_n = EVEN;
                idx_n   = '0;
            end
            EVEN: begin
                state_n = last ? ODD : EVEN;
                idx_n   = last ? '0 : idx + 1'b1;
            end
            ODD: begin
                // Only a slot already flagged full can chain without a bubble.
                state_n = !last ? ODD : full[~rd_slot] ? EVEN : IDLE;
                idx_n   = last ? '0 : idx + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        xv_n   = state != IDLE;
        x_n    = xv_n ? mem[rd_slot][sel] : '0;
        sd_n   = state == EVEN;
        load_n = xv_n && idx == '0;
        bd_n   = row_end && row_cnt == LAST_ROW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= '0;
            wr_slot    <= 1'b0;
            rd_slot    <= 1'b0;
            row_cnt    <= '0;
            x          <= '0;
            sumDiffSel <= 1'b0;
            load       <= 1'b0;
            x_valid    <= 1'b0;
            block_done <= 1'b0;
        end else begin
            if (row_end) begin
                full[rd_slot] <= 1'b0;
                rd_slot       <= ~rd_slot;
                row_cnt       <= row_cnt == LAST_ROW ? '0 : row_cnt + 1'b1;
            end
            if (acc) begin
                full[wr_slot] <= 1'b1;
                wr_slot       <= ~wr_slot;
            end
            x          <= x_n;
            sumDiffSel <= sd_n;
            load       <= load_n;
            x_valid    <= xv_n;
            block_done <= bd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem[wr_slot] <= s_data;
    end
endmodule

// File: tb/tb_dct_row_feeder.sv
// tb_dct_row_feeder: directed and random rows checked against a row-level
// timing model (accept edge -> start/end edges) and a butterfly order table.
module tb_dct_row_feeder;
    localparam int DW = 8, N = 8, RPB = 8, W = N * DW;

    logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic s_ready, sumDiffSel, load, x_valid, block_done;
    logic [DW-1:0] x;

    always #5 clk = ~clk;

    dct_row_feeder #(.DATA_WIDTH(DW), .N(N), .ROWS_PER_BLOCK(RPB)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .x(x), .sumDiffSel(sumDiffSel), .load(load), .x_valid(x_valid), .block_done(block_done)
    );

    int total = 0, bad = 0, cyc = 0, last_end = -100;
    int ord[N];
    logic [W-1:0] rows[$];
    int acc_t[$], st_t[$], en_t[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkrow(input int base);
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(base + k);
        return r;
    endfunction

    function automatic logic [W-1:0] rndrow();
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // A row holds a slot from its accept edge until the edge of its last sample.
    function automatic bit model_ready(input int t);
        int n = 0;
        foreach (acc_t[r]) if (acc_t[r] <= t && t < en_t[r]) n++;
        return n < 2;
    endfunction

    task automatic check_out();
        logic [DW-1:0] ex = '0;
        logic esd = 1'b0, eld = 1'b0, ev = 1'b0, ebd = 1'b0;
        foreach (st_t[r]) if (cyc >= st_t[r] && cyc <= en_t[r]) begin
            int k = cyc - st_t[r];
            int i = k % N;
            logic [W-1:0] row = rows[r];
            ev  = 1'b1;
            esd = k < N;
            eld = i == 0;
            ebd = k == 2 * N - 1 && r % RPB == RPB - 1;
            ex  = row[ord[i]*DW +: DW];
        end
        chk("x_valid", 32'(x_valid), 32'(ev));
        chk("x", 32'(x), 32'(ex));
        chk("sumDiffSel", 32'(sumDiffSel), 32'(esd));
        chk("load", 32'(load), 32'(eld));
        chk("block_done", 32'(block_done), 32'(ebd));
        chk("s_ready", 32'(s_ready), 32'(model_ready(cyc)));
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        bit acc;
        s_valid = v;
        s_data  = d;
        acc = v && model_ready(cyc);
        @(posedge clk);
        cyc++;
        if (acc) begin
            int s = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
            rows.push_back(d);
            acc_t.push_back(cyc);
            st_t.push_back(s);
            en_t.push_back(s + 2 * N - 1);
            last_end = s + 2 * N - 1;
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic check_idle_now(input string tag);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_xv"}, 32'(x_valid), 32'd0);
        chk({tag, "_sd"}, 32'(sumDiffSel), 32'd0);
        chk({tag, "_ld"}, 32'(load), 32'd0);
        chk({tag, "_bd"}, 32'(block_done), 32'd0);
        chk({tag, "_rdy"}, 32'(s_ready), 32'd1);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_now("rst_async");
        rows.delete();
        acc_t.delete();
        st_t.delete();
        en_t.delete();
        last_end = -100;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic stream(input int cnt, input int base, input int inc);
        int n = 0;
        while (n < cnt) begin
            bit r = model_ready(cyc);
            step(1'b1, mkrow(base + inc * n));
            if (r) n++;
        end
    endtask

    initial begin
        for (int j = 0; j < N / 2; j++) begin
            ord[2*j]   = j;
            ord[2*j+1] = N - 1 - j;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_now("reset");
        rst_n = 1'b1;
        step(1'b1, mkrow(1));
        repeat (20) step(1'b0, '0);
        step(1'b1, mkrow(1));
        step(1'b1, mkrow(11));
        repeat (36) step(1'b0, '0);
        stream(3, 20, 10);
        repeat (60) step(1'b0, '0);
        do_reset();
        stream(16, 1, 0);
        repeat (40) step(1'b0, '0);
        step(1'b1, mkrow(1));
        step(1'b1, mkrow(11));
        while (cyc < st_t[0] + 3) step(1'b0, '0);
        do_reset();
        repeat (30) step(1'b0, '0);
        step(1'b1, mkrow(1));
        step(1'b1, mkrow(11));
        step(1'b1, mkrow(100));
        step(1'b0, '0);
        step(1'b1, mkrow(150));
        repeat (50) step(1'b0, '0);
        for (int c = 0; c < 900; c++) step($urandom_range(0, 3) != 0, rndrow());
        repeat (40) step(1'b0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
